// File: rtl/dmi_bridge.sv
// dmi_bridge: DTM-to-DM transport stage. Queues DTM requests, keeps a single
// DMI transaction outstanding, answers NOPs locally and turns a hung DM
// access into a failed response after TIMEOUT cycles in WAIT.
module dmi_bridge #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [1:0]  dmi_req_op,
  output logic [31:0] dmi_req_data,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [1:0]  dmi_resp_resp,
  input  logic [31:0] dmi_resp_data,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [15:0] TMAX    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  // Request FIFO storage and pointers (extra MSB distinguishes full/empty)
  logic [6:0]  fifo_addr_q [DEPTH];
  logic [1:0]  fifo_op_q   [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [6:0]  head_addr;
  logic [1:0]  head_op;
  logic [31:0] head_data;

  // Transaction control state
  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        stale_q, stale_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head_addr = fifo_addr_q[rd_ptr_q[AW-1:0]];
  assign head_op   = fifo_op_q[rd_ptr_q[AW-1:0]];
  assign head_data = fifo_data_q[rd_ptr_q[AW-1:0]];

  assign debug_req_ready = !fifo_full && !reset;
  assign push            = debug_req_valid && debug_req_ready;

  // FIFO payload write on accepted DTM request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[AW-1:0]] <= debug_req_bits_addr;
      fifo_op_q[wr_ptr_q[AW-1:0]]   <= debug_req_bits_op;
      fifo_data_q[wr_ptr_q[AW-1:0]] <= debug_req_bits_data;
    end
  end

  // FIFO pointer advance; push and pop may coincide when non-empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Next-state logic for the single-outstanding transaction sequencer.
  // A late DM response after a timeout is swallowed via the stale flag,
  // which also blocks IDLE from starting anything until it clears.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    stale_d = stale_q;
    tcnt_d  = tcnt_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !stale_q) begin
          if (head_op == 2'd0) begin
            pop     = 1'b1;
            resp_d  = 2'd0;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (dmi_req_ready) begin
          pop     = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the expiry cycle takes priority
        if (dmi_resp_valid) begin
          resp_d  = dmi_resp_resp;
          rdata_d = dmi_resp_data;
          state_d = S_RESP;
        end else if (timer_q == TMAX) begin
          resp_d  = 2'd2;
          rdata_d = '0;
          stale_d = 1'b1;
          if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RESP: begin
        if (debug_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stale_q && (state_q != S_WAIT) && dmi_resp_valid) begin
      stale_d = 1'b0;
    end
  end

  // State, pointer and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      timer_q  <= '0;
      stale_q  <= 1'b0;
      tcnt_q   <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      timer_q  <= timer_d;
      stale_q  <= stale_d;
      tcnt_q   <= tcnt_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Handshake outputs decoded from registered state; forced low in reset
  assign dmi_req_valid    = !reset && (state_q == S_ISSUE);
  assign dmi_resp_ready   = !reset && ((state_q == S_WAIT) || stale_q);
  assign debug_resp_valid = !reset && (state_q == S_RESP);

  assign dmi_req_addr = dmi_req_valid ? head_addr : '0;
  assign dmi_req_op   = dmi_req_valid ? head_op   : '0;
  assign dmi_req_data = dmi_req_valid ? head_data : '0;

  assign debug_resp_bits_resp = debug_resp_valid ? resp_q  : '0;
  assign debug_resp_bits_data = debug_resp_valid ? rdata_q : '0;

  assign busy        = !fifo_empty || (state_q != S_IDLE) || stale_q;
  assign timeout_cnt = tcnt_q;

endmodule
